// File: rtl/event_scheduler.sv
// rtl/event_scheduler.sv - round-robin event scheduler for search-module found/failure reports
//
// Ports:
//   clk, res_n           single clock, synchronous active-low reset
//   found, failure       per-module event levels, held until the module is reset
//   co_buf               per-module polynomial, slice k at [(k+1)*BYTES*8-1 : k*BYTES*8]
//   ev_valid/ev_ack      event handshake towards the host link
//   ev_type              0 = found, 1 = failure
//   ev_idx, ev_poly      module index and polynomial captured at grant
//   mod_res              one-hot, one-cycle reset pulse to the serviced module
//   ev_count             acknowledged events, saturating
//   busy                 high whenever the scheduler is not scanning
module event_scheduler #(
    parameter int NUM_OF_MODULES = 20,
    parameter int BYTES          = 4
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  logic [NUM_OF_MODULES-1:0]          found,
    input  logic [NUM_OF_MODULES-1:0]          failure,
    input  logic [NUM_OF_MODULES*BYTES*8-1:0]  co_buf,
    output logic                               ev_valid,
    output logic                               ev_type,
    output logic [7:0]                         ev_idx,
    output logic [BYTES*8-1:0]                 ev_poly,
    input  logic                               ev_ack,
    output logic [NUM_OF_MODULES-1:0]          mod_res,
    output logic [15:0]                        ev_count,
    output logic                               busy
);

    localparam int N = NUM_OF_MODULES;
    localparam int W = BYTES * 8;

    typedef enum logic [1:0] {SCAN, PRESENT, CLEAR, HOLDOFF} state_t;

    state_t         state_q, state_d;
    logic [7:0]     rr_ptr_q, rr_ptr_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [7:0]     ev_idx_q, ev_idx_d;
    logic           ev_type_q, ev_type_d;
    logic [W-1:0]   ev_poly_q, ev_poly_d;
    logic [15:0]    ev_count_q, ev_count_d;
    logic           hold_q, hold_d;

    logic [N-1:0]   pend;
    logic           hi_any, lo_any;
    logic [7:0]     hi_idx, lo_idx, gnt_idx;
    logic [N-1:0]   gnt_oh, cur_oh;
    logic [W-1:0]   gnt_poly;
    logic           gnt_type;

    assign pend = (found | failure) & ~mask_q;

    // Round-robin search: the lowest pending index at or above rr_ptr wins;
    // if none exists, the lowest pending index overall (wrap-around) wins.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (pend[j]) begin
                lo_any = 1'b1;
                lo_idx = 8'(j);
                if (j >= int'(rr_ptr_q)) begin
                    hi_any = 1'b1;
                    hi_idx = 8'(j);
                end
            end
        end
        gnt_idx  = hi_any ? hi_idx : lo_idx;
        gnt_poly = '0;
        gnt_type = 1'b0;
        gnt_oh   = '0;
        cur_oh   = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(gnt_idx) == j) begin
                gnt_poly  = co_buf[j*W +: W];
                gnt_type  = ~found[j];          // found wins over failure
                gnt_oh[j] = 1'b1;
            end
            if (int'(ev_idx_q) == j) begin
                cur_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        mask_d     = mask_q;
        ev_idx_d   = ev_idx_q;
        ev_type_d  = ev_type_q;
        ev_poly_d  = ev_poly_q;
        ev_count_d = ev_count_q;
        hold_d     = hold_q;
        case (state_q)
            SCAN: begin
                if (lo_any) begin
                    state_d   = PRESENT;
                    ev_idx_d  = gnt_idx;
                    ev_type_d = gnt_type;
                    ev_poly_d = gnt_poly;
                    rr_ptr_d  = (int'(gnt_idx) == N - 1) ? 8'd0 : gnt_idx + 8'd1;
                    mask_d    = mask_q | gnt_oh;
                end
            end
            PRESENT: begin
                if (ev_ack) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                ev_count_d = (ev_count_q == 16'hFFFF) ? ev_count_q : ev_count_q + 16'd1;
                hold_d     = 1'b0;
                state_d    = HOLDOFF;
            end
            HOLDOFF: begin
                // Two cycles give the module time to drop its levels after mod_res.
                if (hold_q) begin
                    hold_d  = 1'b0;
                    mask_d  = mask_q & ~cur_oh;
                    state_d = SCAN;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= SCAN;
            rr_ptr_q   <= '0;
            mask_q     <= '0;
            ev_idx_q   <= '0;
            ev_type_q  <= 1'b0;
            ev_poly_q  <= '0;
            ev_count_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            mask_q     <= mask_d;
            ev_idx_q   <= ev_idx_d;
            ev_type_q  <= ev_type_d;
            ev_poly_q  <= ev_poly_d;
            ev_count_q <= ev_count_d;
            hold_q     <= hold_d;
        end
    end

    assign ev_valid = (state_q == PRESENT);
    assign busy     = (state_q != SCAN);
    assign mod_res  = (state_q == CLEAR) ? cur_oh : '0;
    assign ev_idx   = ev_idx_q;
    assign ev_type  = ev_type_q;
    assign ev_poly  = ev_poly_q;
    assign ev_count = ev_count_q;

endmodule

// File: tb/tb_event_scheduler.sv
// tb/tb_event_scheduler.sv - directed table-driven bench for event_scheduler
module tb_event_scheduler;

    localparam int N = 20;

    logic          clk = 1'b0;
    logic          res_n;
    logic [N-1:0]  found, failure;
    logic [N*32-1:0] co_buf;
    logic          ev_valid, ev_type, ev_ack, busy;
    logic [7:0]    ev_idx;
    logic [31:0]   ev_poly;
    logic [N-1:0]  mod_res;
    logic [15:0]   ev_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    event_scheduler #(.NUM_OF_MODULES(N), .BYTES(4)) dut (
        .clk(clk), .res_n(res_n), .found(found), .failure(failure), .co_buf(co_buf),
        .ev_valid(ev_valid), .ev_type(ev_type), .ev_idx(ev_idx), .ev_poly(ev_poly),
        .ev_ack(ev_ack), .mod_res(mod_res), .ev_count(ev_count), .busy(busy)
    );

    typedef struct {
        logic          rn;
        logic [N-1:0]  f;
        logic [N-1:0]  fl;
        logic          ack;
        logic          valid;
        logic [7:0]    idx;
        logic          typ;
        logic [31:0]   poly;
        logic [N-1:0]  mres;
        logic [15:0]   cnt;
        logic          bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [N-1:0] b(input int k);
        logic [N-1:0] one;
        one = 1;
        return one << k;
    endfunction

    function automatic logic [31:0] slice(input int k);
        if (k == 3) return 32'hDEADBEEF;
        return 32'hA5000000 | 32'(k);
    endfunction

    function automatic vec_t mk(input logic rn, input logic [N-1:0] f, input logic [N-1:0] fl,
                                input logic ack, input logic valid, input int idx, input logic typ,
                                input logic [31:0] poly, input logic [N-1:0] mres,
                                input int cnt, input logic bsy);
        vec_t v;
        v.rn = rn; v.f = f; v.fl = fl; v.ack = ack; v.valid = valid; v.idx = 8'(idx);
        v.typ = typ; v.poly = poly; v.mres = mres; v.cnt = 16'(cnt); v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_event(input int k, input int exp_cnt);
        found = b(k); ev_ack = 1'b1;
        step();
        check("evt_valid", 64'(ev_valid), 64'd1);
        check("evt_idx", 64'(ev_idx), 64'(k));
        step();
        check("evt_mod_res", 64'(mod_res), 64'(b(k)));
        found = '0; ev_ack = 1'b0;
        step();
        check("evt_count", 64'(ev_count), 64'(exp_cnt));
        step();
        step();
        check("evt_idle", 64'(busy), 64'd0);
    endtask

    logic [N-1:0] rr_set, fl_set;
    logic [31:0]  held_poly;
    int           ngrant, last_cyc, cyc;
    logic         prev_valid, seen;

    initial begin
        res_n = 1'b0; found = '0; failure = '0; ev_ack = 1'b0;
        for (int k = 0; k < N; k++) co_buf[k*32 +: 32] = slice(k);

        rr_set = b(2) | b(7);
        fl_set = b(15);
        // rn, found, failure, ack | valid, idx, typ, poly, mod_res, count, busy
        vecs.push_back(mk(0, '0, '0, 0,   0, 0, 0, 32'h0, '0, 0, 0));
        vecs.push_back(mk(1, b(3), '0, 0, 1, 3, 0, slice(3), '0, 0, 1));
        vecs.push_back(mk(1, b(3), '0, 1, 0, 3, 0, slice(3), b(3), 0, 1));
        vecs.push_back(mk(1, '0, '0, 0,   0, 3, 0, slice(3), '0, 1, 1));
        vecs.push_back(mk(1, '0, '0, 0,   0, 3, 0, slice(3), '0, 1, 1));
        vecs.push_back(mk(1, '0, '0, 0,   0, 3, 0, slice(3), '0, 1, 0));
        vecs.push_back(mk(1, '0, '0, 0,   0, 3, 0, slice(3), '0, 1, 0));
        vecs.push_back(mk(0, '0, '0, 0,   0, 0, 0, 32'h0, '0, 0, 0));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 1, 2, 0, slice(2), '0, 0, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 2, 0, slice(2), b(2), 0, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 2, 0, slice(2), '0, 1, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 2, 0, slice(2), '0, 1, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 2, 0, slice(2), '0, 1, 0));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 1, 7, 0, slice(7), '0, 1, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 7, 0, slice(7), b(7), 1, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 7, 0, slice(7), '0, 2, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 7, 0, slice(7), '0, 2, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 7, 0, slice(7), '0, 2, 0));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 1, 15, 1, slice(15), '0, 2, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 15, 1, slice(15), b(15), 2, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 15, 1, slice(15), '0, 3, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 15, 1, slice(15), '0, 3, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 15, 1, slice(15), '0, 3, 0));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 1, 2, 0, slice(2), '0, 3, 1));
        vecs.push_back(mk(1, rr_set, fl_set, 1, 0, 2, 0, slice(2), b(2), 3, 1));
        vecs.push_back(mk(1, '0, '0, 0,   0, 2, 0, slice(2), '0, 4, 1));
        vecs.push_back(mk(1, '0, '0, 0,   0, 2, 0, slice(2), '0, 4, 1));
        vecs.push_back(mk(1, '0, '0, 0,   0, 2, 0, slice(2), '0, 4, 0));
        vecs.push_back(mk(1, '0, '0, 0,   0, 2, 0, slice(2), '0, 4, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            res_n = vecs[i].rn; found = vecs[i].f; failure = vecs[i].fl; ev_ack = vecs[i].ack;
            step();
            check($sformatf("v%0d_valid", i), 64'(ev_valid), 64'(vecs[i].valid));
            check($sformatf("v%0d_idx", i), 64'(ev_idx), 64'(vecs[i].idx));
            check($sformatf("v%0d_type", i), 64'(ev_type), 64'(vecs[i].typ));
            check($sformatf("v%0d_poly", i), 64'(ev_poly), 64'(vecs[i].poly));
            check($sformatf("v%0d_mod_res", i), 64'(mod_res), 64'(vecs[i].mres));
            check($sformatf("v%0d_count", i), 64'(ev_count), 64'(vecs[i].cnt));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
        end

        // Simultaneous found/failure on one module: one event, found wins.
        found = b(5); failure = b(5); ev_ack = 1'b1;
        step();
        check("both_valid", 64'(ev_valid), 64'd1);
        check("both_idx", 64'(ev_idx), 64'd5);
        check("both_type", 64'(ev_type), 64'd0);
        step();
        check("both_mod_res", 64'(mod_res), 64'(b(5)));
        found = '0; failure = '0; ev_ack = 1'b0;
        step(); step(); step();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ev_valid || busy) seen = 1'b1;
        end
        check("both_no_second", 64'(seen), 64'd0);
        check("both_count", 64'(ev_count), 64'd5);

        // Back-pressure with toggling level and changing co_buf.
        found = b(9);
        step();
        check("bp_valid", 64'(ev_valid), 64'd1);
        check("bp_poly", 64'(ev_poly), 64'(slice(9)));
        held_poly = slice(9);
        co_buf[9*32 +: 32] = 32'h12345678;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            found[9] = i[0];
            step();
            if (!ev_valid || ev_idx != 8'd9 || ev_type || ev_poly != held_poly || mod_res != '0)
                seen = 1'b1;
        end
        check("bp_stable", 64'(seen), 64'd0);
        found = b(9); ev_ack = 1'b1;
        step();
        check("bp_mod_res", 64'(mod_res), 64'(b(9)));
        check("bp_valid_drop", 64'(ev_valid), 64'd0);
        found = '0; ev_ack = 1'b0;
        step(); step(); step();
        check("bp_count", 64'(ev_count), 64'd6);
        co_buf[9*32 +: 32] = slice(9);

        // Reset while presenting, with ack asserted in the same cycle.
        found = b(11);
        step();
        check("rst_pre_valid", 64'(ev_valid), 64'd1);
        res_n = 1'b0; ev_ack = 1'b1;
        step();
        check("rst_valid", 64'(ev_valid), 64'd0);
        check("rst_idx", 64'(ev_idx), 64'd0);
        check("rst_poly", 64'(ev_poly), 64'd0);
        check("rst_mod_res", 64'(mod_res), 64'd0);
        check("rst_count", 64'(ev_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        res_n = 1'b1; ev_ack = 1'b0;
        step();
        check("rst_regrant_valid", 64'(ev_valid), 64'd1);
        check("rst_regrant_idx", 64'(ev_idx), 64'd11);
        ev_ack = 1'b1;
        step();
        check("rst_regrant_mod_res", 64'(mod_res), 64'(b(11)));
        found = '0; ev_ack = 1'b0;
        step(); step(); step();
        check("rst_regrant_count", 64'(ev_count), 64'd1);

        // Fairness and throughput: all modules pending, immediate ack. rr_ptr is 12.
        found = '1; ev_ack = 1'b1;
        ngrant = 0; last_cyc = 0; prev_valid = 1'b0;
        for (cyc = 1; cyc <= 400 && ngrant < 40; cyc++) begin
            step();
            if (ev_valid && !prev_valid) begin
                check($sformatf("fair_idx%0d", ngrant), 64'(ev_idx), 64'((12 + ngrant) % N));
                if (ngrant > 0) check("fair_spacing", 64'(cyc - last_cyc), 64'd5);
                last_cyc = cyc;
                ngrant++;
                if (ngrant == 40) found = '0;
            end
            prev_valid = ev_valid;
        end
        check("fair_grants", 64'(ngrant), 64'd40);
        found = '0;
        for (int i = 0; i < 20 && busy; i++) step();
        ev_ack = 1'b0;
        check("fair_idle", 64'(busy), 64'd0);
        check("fair_count", 64'(ev_count), 64'd41);

        // Saturation: preload the counter near the top, then acknowledge three events.
        force dut.ev_count_q = 16'hFFFD;
        step();
        release dut.ev_count_q;
        step();
        check("sat_preload", 64'(ev_count), 64'hFFFD);
        run_event(0, 16'hFFFE);
        run_event(0, 16'hFFFF);
        run_event(0, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
